// File: rtl/spio_hss_multiplexer_rx_link_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spio_hss_multiplexer_rx_link_ctrl_pkg
//   Shared definitions for the HSS multiplexer receive link controller:
//   frame/K-char widths, idle and clock-correction word patterns, link
//   state encodings, register widths and the received-word classifier.
// ---------------------------------------------------------------------------
package spio_hss_multiplexer_rx_link_ctrl_pkg;

  localparam int FRM_BITS  = 32;
  localparam int KCH_BITS  = 4;
  localparam int CERR_BITS = 16;
  localparam int LOS_BITS  = 8;

  localparam logic [FRM_BITS-1:0] SYNC_WORD = 32'hB5B5_B5BC;
  localparam logic [FRM_BITS-1:0] CLKC_WORD = 32'hF7F7_F7FC;
  localparam logic [KCH_BITS-1:0] SYNC_KCHR = 4'b0001;

  // Encoding is visible to software through reg_lsts.
  typedef enum logic [1:0] {
    LINK_LOS = 2'd0,
    LINK_ACQ = 2'd1,
    LINK_UP  = 2'd2
  } link_state_e;

  typedef enum logic [1:0] {
    WORD_DATA = 2'd0,
    WORD_SYNC = 2'd1,
    WORD_CLKC = 2'd2,
    WORD_ERR  = 2'd3
  } word_class_e;

  // A code error in any byte wins over pattern matching; frame K-chars
  // that are neither idle nor clock-correction fall through to DATA.
  function automatic word_class_e classify(
    input logic [FRM_BITS-1:0] data,
    input logic [KCH_BITS-1:0] kchr,
    input logic [3:0]          cerr
  );
    if (|cerr) return WORD_ERR;
    if ((kchr == SYNC_KCHR) && (data == SYNC_WORD)) return WORD_SYNC;
    if ((kchr == SYNC_KCHR) && (data == CLKC_WORD)) return WORD_CLKC;
    return WORD_DATA;
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_sat_counter.sv
// ---------------------------------------------------------------------------
// spio_hss_multiplexer_sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-low reset, clears the count
//   i_inc  in  count one event this cycle
//   o_cnt  out current count (WIDTH bits)
// ---------------------------------------------------------------------------
module spio_hss_multiplexer_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Increment on request unless already saturated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/spio_hss_multiplexer_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// spio_hss_multiplexer_rx_link_ctrl
//   Receive-side link controller between the serial transceiver word output
//   and the frame disassembler. Acquires word sync on a run of SYNC idles,
//   strips idle/clock-correction words while UP, and drops the link when too
//   many code errors land inside one window of good words.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   gt_data/kchr/cerr raw word, per-byte K flags, per-byte code errors
//   gt_vld            raw word valid
//   hsl_data/kchr/vld forwarded frame word (one register stage)
//   link_up           link in UP state
//   reg_cerr          saturating count of code-error words seen while UP
//   reg_los           saturating count of UP -> LOS events
//   reg_lsts          link state (LOS=0, ACQ=1, UP=2)
// ---------------------------------------------------------------------------
module spio_hss_multiplexer_rx_link_ctrl
  import spio_hss_multiplexer_rx_link_ctrl_pkg::*;
#(
  parameter int SYNC_CNT  = 16,
  parameter int BAD_LIMIT = 4,
  parameter int WIN       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FRM_BITS-1:0]  gt_data,
  input  logic [KCH_BITS-1:0]  gt_kchr,
  input  logic [3:0]           gt_cerr,
  input  logic                 gt_vld,
  output logic [FRM_BITS-1:0]  hsl_data,
  output logic [KCH_BITS-1:0]  hsl_kchr,
  output logic                 hsl_vld,
  output logic                 link_up,
  output logic [CERR_BITS-1:0] reg_cerr,
  output logic [LOS_BITS-1:0]  reg_los,
  output logic [1:0]           reg_lsts
);

  localparam int ACQ_W  = $clog2(SYNC_CNT + 1);
  localparam int GOOD_W = $clog2(WIN + 1);
  localparam int BAD_W  = $clog2(BAD_LIMIT + 1);

  // Count values held just before the deciding word arrives.
  localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(SYNC_CNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(WIN - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);

  link_state_e       r_state, w_state_nxt;
  logic [ACQ_W-1:0]  r_acq_cnt, w_acq_nxt;
  logic [GOOD_W-1:0] r_good_cnt, w_good_nxt;
  logic [BAD_W-1:0]  r_bad_cnt, w_bad_nxt;
  word_class_e       w_class;
  logic              w_fwd;
  logic              w_cerr_inc;
  logic              w_los_inc;

  logic [FRM_BITS-1:0] r_hsl_data;
  logic [KCH_BITS-1:0] r_hsl_kchr;
  logic                r_hsl_vld;

  assign w_class = classify(gt_data, gt_kchr, gt_cerr);

  // State and link counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LINK_LOS;
      r_acq_cnt  <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acq_cnt  <= w_acq_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
    end
  end

  // Next-state logic; idle cycles (gt_vld=0) leave everything untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_acq_nxt   = r_acq_cnt;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_fwd       = 1'b0;
    w_cerr_inc  = 1'b0;
    w_los_inc   = 1'b0;
    if (gt_vld) begin
      case (r_state)
        LINK_LOS: begin
          if (w_class == WORD_SYNC) begin
            w_state_nxt = LINK_ACQ;
            w_acq_nxt   = ACQ_W'(1);
          end
        end
        LINK_ACQ: begin
          case (w_class)
            WORD_SYNC: begin
              if (r_acq_cnt == ACQ_LAST) begin
                w_state_nxt = LINK_UP;
                w_acq_nxt   = '0;
                w_good_nxt  = '0;
                w_bad_nxt   = '0;
              end else begin
                w_acq_nxt = r_acq_cnt + ACQ_W'(1);
              end
            end
            WORD_CLKC: ;
            // Never reached UP, so this is not a loss-of-sync event.
            default: begin
              w_state_nxt = LINK_LOS;
              w_acq_nxt   = '0;
            end
          endcase
        end
        LINK_UP: begin
          if (w_class == WORD_ERR) begin
            w_cerr_inc = 1'b1;
            if (r_bad_cnt == BAD_LAST) begin
              w_state_nxt = LINK_LOS;
              w_los_inc   = 1'b1;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_bad_nxt = r_bad_cnt + BAD_W'(1);
            end
          end else begin
            // Idles are dropped but still close the error window.
            w_fwd = (w_class == WORD_DATA);
            if (r_good_cnt == GOOD_LAST) begin
              w_good_nxt = '0;
              w_bad_nxt  = '0;
            end else begin
              w_good_nxt = r_good_cnt + GOOD_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = LINK_LOS;
          w_acq_nxt   = '0;
        end
      endcase
    end
  end

  // Output stage: valid pulses for one cycle, data holds between words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsl_vld  <= 1'b0;
      r_hsl_data <= '0;
      r_hsl_kchr <= '0;
    end else begin
      r_hsl_vld <= w_fwd;
      if (w_fwd) begin
        r_hsl_data <= gt_data;
        r_hsl_kchr <= gt_kchr;
      end
    end
  end

  spio_hss_multiplexer_sat_counter #(.WIDTH(CERR_BITS)) u_cerr_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_cerr_inc),
    .o_cnt (reg_cerr)
  );

  spio_hss_multiplexer_sat_counter #(.WIDTH(LOS_BITS)) u_los_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_los_inc),
    .o_cnt (reg_los)
  );

  assign hsl_data = r_hsl_data;
  assign hsl_kchr = r_hsl_kchr;
  assign hsl_vld  = r_hsl_vld;
  assign link_up  = (r_state == LINK_UP);
  assign reg_lsts = r_state;

endmodule
